// File: rtl/platform_pio_in_edge_if.sv
// platform_pio_in_edge_if: Avalon-MM slave bus of the PIO input port
interface platform_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/platform_pio_in_edge.sv
// platform_pio_in_edge: synchronised input port with W1C edge capture and maskable irq
// Optional per-bit debounce filter is built in when PIO_IN_DEBOUNCE_EN is defined.
module platform_pio_in_edge #(
    parameter int DATA_WIDTH      = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                  clk,
    input logic                  reset_n,
    platform_pio_in_edge_if.slave bus,
    input logic [DATA_WIDTH-1:0] in_port
);
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int ARM_LEN = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
`else
    localparam int ARM_LEN = SYNC_STAGES + 1;
`endif
    localparam int ARM_W = $clog2(ARM_LEN + 1);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] sync, filtered, prev, edge_term, edge_capture, irq_mask, w1c;
    logic [ARM_W-1:0]      arm_cnt;
    logic                  armed, wr;

    assign sync = sync_q[SYNC_STAGES-1];

    // synchroniser chain for the asynchronous inputs
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DATA_WIDTH-1:0][CNT_W-1:0] db_cnt;

    // a bit follows sync only after differing from it for DEBOUNCE_CYCLES consecutive clocks
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            filtered <= '0;
            db_cnt   <= '0;
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++)
                if (sync[i] == filtered[i]) db_cnt[i] <= '0;
                else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    filtered[i] <= sync[i];
                    db_cnt[i]   <= '0;
                end else db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
`else
    assign filtered = sync;
`endif

    assign armed     = arm_cnt == ARM_W'(ARM_LEN);
    assign wr        = bus.chipselect && !bus.write_n;
    assign w1c       = (wr && bus.address == 2'd3) ? bus.writedata[DATA_WIDTH-1:0] : '0;
    assign edge_term = !armed          ? '0 :
                       EDGE_TYPE == 0  ? filtered & ~prev :
                       EDGE_TYPE == 1  ? ~filtered & prev : filtered ^ prev;
    assign bus.irq   = |(edge_capture & irq_mask);

    // arming window, previous sample, edge capture (set beats clear) and irq mask
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            arm_cnt      <= '0;
            prev         <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
            prev         <= filtered;
            edge_capture <= (edge_capture & ~w1c) | edge_term;
            if (wr && bus.address == 2'd2) irq_mask <= bus.writedata[DATA_WIDTH-1:0];
        end

    // read mux registered every cycle, independent of chipselect
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) bus.readdata <= '0;
        else bus.readdata <= bus.address == 2'd0 ? 32'(filtered) :
                             bus.address == 2'd2 ? 32'(irq_mask) :
                             bus.address == 2'd3 ? 32'(edge_capture) : 32'd0;
endmodule
